// File: rtl/fir_fp_pkg.sv
// Shared FIR floating-point definitions.
// Provides field widths and bias constants for the FP29i accumulator format
// and the IEEE half-precision output format, plus the FP29i word typedef.
package fir_fp_pkg;

  // FP29i: sign / 7-bit exponent / 22-bit explicit mantissa.
  localparam int FP29I_S_W  = 1;
  localparam int FP29I_E_W  = 7;
  localparam int FP29I_M_W  = 22;
  localparam int FP29I_W    = FP29I_S_W + FP29I_E_W + FP29I_M_W;

  // FP16: sign / 5-bit exponent / 10-bit fraction.
  localparam int FP16_S_W   = 1;
  localparam int FP16_E_W   = 5;
  localparam int FP16_F_W   = 10;
  localparam int FP16_W     = FP16_S_W + FP16_E_W + FP16_F_W;

  localparam int FP29I_BIAS   = 63;
  localparam int FP29I_MPOINT = 20;
  localparam int FP16_BIAS    = 15;

  localparam logic [FP16_W-1:0] FP16_PINF = 16'h7C00;

  // Biased FP16 exponent = e + p - BE_OFFSET, where p is the leading-one
  // position of the mantissa (value = m/2^20 * 2^(e-63)).
  localparam int BE_OFFSET = FP29I_BIAS + FP29I_MPOINT - FP16_BIAS;

  typedef struct packed {
    logic                 s;
    logic [FP29I_E_W-1:0] e;
    logic [FP29I_M_W-1:0] m;
  } fp29i_t;

endpackage

// File: rtl/fir_out_fp16_pack_if.sv
// Bus between the FIR controller/ALU and the FP16 output packer.
//   master : drives in_valid, in_data, flag_clr; observes results
//   slave  : the packer; drives dout, valid, ovf, unf, busy
interface fir_out_fp16_pack_if;
  import fir_fp_pkg::*;

  logic               in_valid;
  logic [FP29I_W-1:0] in_data;
  logic               flag_clr;
  logic [FP16_W-1:0]  dout;
  logic               valid;
  logic               ovf;
  logic               unf;
  logic               busy;

  modport master (
    output in_valid, in_data, flag_clr,
    input  dout, valid, ovf, unf, busy
  );

  modport slave (
    input  in_valid, in_data, flag_clr,
    output dout, valid, ovf, unf, busy
  );

endinterface

// File: rtl/fp29i_lzd.sv
// Combinational leading-one detector for the 22-bit FP29i mantissa.
//   m    : mantissa
//   p    : index of the most significant set bit (0 when m == 0)
//   zero : m == 0
module fp29i_lzd
  import fir_fp_pkg::*;
(
  input  logic [FP29I_M_W-1:0] m,
  output logic [4:0]           p,
  output logic                 zero
);

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no latch can be inferred.
  always_comb begin
    p = '0;
    // Ascending scan: the highest set bit is the last one to write p.
    for (int i = 0; i < FP29I_M_W; i++) begin
      if (m[i]) p = 5'(i);
    end
  end

  assign zero = ~|m;

endmodule

// File: rtl/fir_out_fp16_pack.sv
// FIR output packer: FP29i accumulator result -> IEEE FP16.
// Three registered stages: leading-one detect, round-to-nearest-even,
// saturate/flush and pack. Fixed latency, one result per cycle, no stall.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : in_valid/in_data/flag_clr in; dout/valid/ovf/unf/busy out
module fir_out_fp16_pack
  import fir_fp_pkg::*;
#(
  parameter int PIPE_STAGES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  fir_out_fp16_pack_if.slave  bus
);

  fp29i_t in_w;
  assign in_w = fp29i_t'(bus.in_data);

  // ---------------- Stage 1: leading-one detect ----------------
  logic [4:0]        p_c;
  logic              zero_c;
  logic signed [8:0] be_c;

  fp29i_lzd u_lzd (
    .m    (in_w.m),
    .p    (p_c),
    .zero (zero_c)
  );

  assign be_c = 9'(in_w.e) + 9'(p_c) - 9'(BE_OFFSET);

  logic [PIPE_STAGES-1:0] stg_v;
  logic                   s1_s, s1_zero;
  logic [FP29I_M_W-1:0]   s1_m;
  logic [4:0]             s1_p;
  logic signed [8:0]      s1_be;

  // ---------------- Stage 2: normalize and round ----------------
  // Shifting the leading one up to bit 21 lines frac/guard/sticky up at
  // fixed positions; for p <= 10 the low bits fill with zeros, which gives
  // the exact left-aligned fraction with guard = sticky = 0.
  logic [4:0]        sh_c;
  logic [20:0]       mn_c;
  logic [9:0]        frac_raw_c;
  logic              guard_c, sticky_c, round_up_c;
  logic [10:0]       frac_sum_c;
  logic signed [8:0] be_r_c;

  assign sh_c       = 5'(FP29I_M_W - 1) - s1_p;
  assign mn_c       = 21'(s1_m << sh_c);
  assign frac_raw_c = mn_c[20:11];
  assign guard_c    = mn_c[10];
  assign sticky_c   = |mn_c[9:0];
  assign round_up_c = guard_c & (sticky_c | frac_raw_c[0]);
  assign frac_sum_c = {1'b0, frac_raw_c} + {10'b0, round_up_c};
  // On a carry-out the low 10 bits have already wrapped to zero.
  assign be_r_c     = s1_be + $signed({8'b0, frac_sum_c[10]});

  logic              s2_s, s2_zero;
  logic [9:0]        s2_frac;
  logic signed [8:0] s2_be;

  // ---------------- Stage 3: saturate, flush, pack ----------------
  logic [FP16_W-1:0] pack_c;
  logic              ovf_evt_c, unf_evt_c;

  always_comb begin
    pack_c    = {s2_s, s2_be[4:0], s2_frac};
    ovf_evt_c = 1'b0;
    unf_evt_c = 1'b0;
    if (s2_zero) begin
      pack_c = {s2_s, 15'h0};
    end else if (s2_be >= 9'sd31) begin
      pack_c    = {s2_s, FP16_PINF[14:0]};
      ovf_evt_c = 1'b1;
    end else if (s2_be <= 9'sd0) begin
      // Subnormal range is flushed to signed zero.
      pack_c    = {s2_s, 15'h0};
      unf_evt_c = 1'b1;
    end
  end

  logic [FP16_W-1:0] dout_q;
  logic              ovf_q, unf_q;

  // NOTE: all sequential state uses non-blocking assignments so every
  // stage samples the previous stage's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_v   <= '0;
      s1_s    <= 1'b0;
      s1_zero <= 1'b0;
      s1_m    <= '0;
      s1_p    <= '0;
      s1_be   <= '0;
      s2_s    <= 1'b0;
      s2_zero <= 1'b0;
      s2_frac <= '0;
      s2_be   <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      stg_v <= {stg_v[PIPE_STAGES-2:0], bus.in_valid};
      // Data registers load only with their valid bit, so idle (possibly X)
      // input never reaches dout.
      if (bus.in_valid) begin
        s1_s    <= in_w.s;
        s1_zero <= zero_c;
        s1_m    <= in_w.m;
        s1_p    <= p_c;
        s1_be   <= be_c;
      end
      if (stg_v[0]) begin
        s2_s    <= s1_s;
        s2_zero <= s1_zero;
        s2_frac <= frac_sum_c[9:0];
        s2_be   <= be_r_c;
      end
      if (stg_v[1]) dout_q <= pack_c;
      // A new event beats a simultaneous clear.
      ovf_q <= (stg_v[1] & ovf_evt_c) | (ovf_q & ~bus.flag_clr);
      unf_q <= (stg_v[1] & unf_evt_c) | (unf_q & ~bus.flag_clr);
    end
  end

  assign bus.dout  = dout_q;
  assign bus.valid = stg_v[PIPE_STAGES-1];
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
  assign bus.busy  = |stg_v;

endmodule

// File: tb/tb_fir_out_fp16_pack.sv
// Self-checking bench for fir_out_fp16_pack: directed vector table,
// flag sequences, random streaming against a reference model, and
// reset during an in-flight burst. Results are matched via a scoreboard.
module tb_fir_out_fp16_pack;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n_valid = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_out_fp16_pack_if bus ();

  fir_out_fp16_pack #(.PIPE_STAGES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] dout;
    int          due;
  } sb_t;

  typedef struct {
    logic [29:0] din;
    logic [15:0] dout;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference conversion: returns {ovf_evt, unf_evt, dout}.
  function automatic logic [17:0] ref_conv(input logic [29:0] d);
    logic s;
    int   e, mi, p, be, frac, g, st;
    s  = d[29];
    e  = int'(d[28:22]);
    mi = int'(d[21:0]);
    if (mi == 0) return {2'b00, s, 15'h0};
    p = 0;
    for (int i = 0; i < 22; i++) if (mi[i]) p = i;
    be = e + p - 68;
    if (p >= 11) begin
      frac = (mi >> (p - 10)) & 'h3FF;
      g    = (mi >> (p - 11)) & 1;
      st   = ((mi & ((1 << (p - 11)) - 1)) != 0) ? 1 : 0;
      if (g == 1 && (st == 1 || frac[0])) frac = frac + 1;
      if (frac == 1024) begin
        frac = 0;
        be   = be + 1;
      end
    end else begin
      frac = (mi << (10 - p)) & 'h3FF;
    end
    if (be >= 31) return {2'b10, s, 5'h1F, 10'h0};
    if (be <= 0)  return {2'b01, s, 15'h0};
    return {2'b00, s, be[4:0], frac[9:0]};
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && bus.valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'(bus.valid), 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("dout", 32'(bus.dout), 32'(e.dout));
        check("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Drive one input word now, then advance to the next falling edge.
  task automatic send(input logic [29:0] d, input logic [15:0] exp);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    sb_q.push_back('{exp, cyc + 3});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 'x;
  endtask

  // Wait (bounded) for all expected results, then realign to a falling edge.
  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [29:0] d;

    vecs.push_back('{30'h0FD00000, 16'h3C00}); // 1.0
    vecs.push_back('{30'h0FD00200, 16'h3C00}); // tie, even -> down
    vecs.push_back('{30'h0FD00600, 16'h3C02}); // tie, odd -> up
    vecs.push_back('{30'h0FDFFE00, 16'h4000}); // carry into exponent
    vecs.push_back('{30'h0FE00000, 16'h4000}); // p = 21
    vecs.push_back('{30'h1FD00000, 16'h7C00}); // overflow
    vecs.push_back('{30'h2A100000, 16'h8000}); // underflow, negative
    vecs.push_back('{30'h2FC00000, 16'h8000}); // negative zero
    vecs.push_back('{30'h0FC00001, 16'h0000}); // be = -5
    vecs.push_back('{30'h13900000, 16'h7800}); // be = 30, largest exponent
    vecs.push_back('{30'h139FFE00, 16'h7C00}); // rounding pushes to be = 31
    vecs.push_back('{30'h0C500000, 16'h0400}); // be = 1
    vecs.push_back('{30'h0C100000, 16'h0000}); // be = 0 flushed
    vecs.push_back('{30'h0FC00400, 16'h1400}); // p = 10 exact
    vecs.push_back('{30'h0FC00403, 16'h1403}); // p = 10 with fraction

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flag_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout",  32'(bus.dout),  32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_ovf",   32'(bus.ovf),   32'h0);
    check("rst_unf",   32'(bus.unf),   32'h0);
    check("rst_busy",  32'(bus.busy),  32'h0);

    // Input in the first cycle after release; single isolated conversion.
    rst_n = 1'b1;
    n0 = n_valid;
    send(30'h0FD00000, 16'h3C00);
    check("busy_inflight", 32'(bus.busy), 32'h1);
    repeat (5) @(negedge clk);
    #1;
    check("single_pulse_count", 32'(n_valid - n0), 32'd1);
    check("dout_held", 32'(bus.dout), 32'h3C00);
    check("busy_idle", 32'(bus.busy), 32'h0);
    @(negedge clk);

    // Directed table, back to back.
    foreach (vecs[i]) send(vecs[i].din, vecs[i].dout);
    drain();
    check("ovf_set", 32'(bus.ovf), 32'h1);
    check("unf_set", 32'(bus.unf), 32'h1);
    repeat (4) @(negedge clk);
    check("ovf_sticky", 32'(bus.ovf), 32'h1);
    check("unf_sticky", 32'(bus.unf), 32'h1);

    bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    check("ovf_cleared", 32'(bus.ovf), 32'h0);
    check("unf_cleared", 32'(bus.unf), 32'h0);

    // Zero raises no flag.
    send(30'h2FC00000, 16'h8000);
    drain();
    check("zero_no_unf", 32'(bus.unf), 32'h0);
    check("zero_no_ovf", 32'(bus.ovf), 32'h0);

    // Clear coincident with a new overflow event: event wins.
    send(30'h1FD00000, 16'h7C00);
    @(negedge clk);
    bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    check("ovf_clr_coincident", 32'(bus.ovf), 32'h1);
    check("unf_clr_coincident", 32'(bus.unf), 32'h0);
    drain();

    // Random streaming.
    n0 = n_valid;
    for (int i = 0; i < 64; i++) begin
      d = 30'($urandom);
      send(d, ref_conv(d)[15:0]);
    end
    drain();
    check("stream_count", 32'(n_valid - n0), 32'd64);

    // Reset with conversions in flight.
    send(30'h1FD00000, 16'h7C00);
    drain();
    check("pre_reset_ovf", 32'(bus.ovf), 32'h1);
    bus.in_valid = 1'b1;
    bus.in_data  = 30'h0FD00000;
    @(negedge clk);
    bus.in_data  = 30'h1FD00000;
    @(negedge clk);
    bus.in_data  = 30'h0FDFFE00;
    #2;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("async_rst_dout", 32'(bus.dout),  32'h0);
    check("async_rst_busy", 32'(bus.busy),  32'h0);
    check("async_rst_ovf",  32'(bus.ovf),   32'h0);
    check("async_rst_valid",32'(bus.valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_valid;
    repeat (8) @(negedge clk);
    #1;
    check("post_rst_no_valid", 32'(n_valid - n0), 32'd0);
    check("post_rst_dout", 32'(bus.dout), 32'h0);
    check("post_rst_ovf",  32'(bus.ovf),  32'h0);
    check("post_rst_unf",  32'(bus.unf),  32'h0);
    check("post_rst_busy", 32'(bus.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
